// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB receive CRC path.
//   pkt_type_e       packet class sampled with start
//   CRC5_* / CRC16_* width, polynomial, init value and good residue
//   *_LEN            covered-bit length limits (count is 14 bits)
//   crc5_next/crc16_next  one-bit CRC step, LSB-first wire order
package usb_pkg;

   typedef enum logic [1:0] {
      PKT_DATA   = 2'd0,
      PKT_TOKEN  = 2'd1,
      PKT_HSHAKE = 2'd2
   } pkt_type_e;

   localparam int          CRC5_W        = 5;
   localparam logic [4:0]  CRC5_POLY     = 5'b00101;
   localparam logic [4:0]  CRC5_INIT     = 5'h1F;
   localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;

   localparam int          CRC16_W       = 16;
   localparam logic [15:0] CRC16_POLY    = 16'h8005;
   localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

   localparam int          CNT_W         = 14;
   localparam logic [13:0] CNT_MAX       = 14'h3FFF;
   localparam logic [13:0] TOKEN_LEN     = 14'd16;
   localparam logic [13:0] DATA_MIN_LEN  = 14'd16;
   localparam logic [13:0] DATA_MAX_LEN  = 14'd8200;   // 1023 payload bytes + CRC16

   function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic b);
      return {c[3:0], 1'b0} ^ ((c[4] ^ b) ? CRC5_POLY : 5'd0);
   endfunction

   function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'd0);
   endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// usb_crc_lfsr: serial CRC register, MSB feedback.
//   clk, rst_n  clock, async active-low reset (register -> INIT)
//   clr_i       reload INIT; if en_i is also high the bit is applied to INIT
//   en_i        consume bit_i this cycle
//   bit_i       serial data bit
//   crc_o       current CRC register
module usb_crc_lfsr #(
   parameter int           W    = 16,
   parameter logic [W-1:0] POLY = '0,
   parameter logic [W-1:0] INIT = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         bit_i,
   output logic [W-1:0] crc_o
);

   logic [W-1:0] crc_q, crc_d, base;

   always_comb begin
      base  = clr_i ? INIT : crc_q;
      crc_d = base;
      if (en_i)
         crc_d = {base[W-2:0], 1'b0} ^ ((base[W-1] ^ bit_i) ? POLY : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= INIT;
      else        crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/usb_crc_check.sv
// usb_crc_check: receive-side CRC5/CRC16 checker and CRC-field stripper.
//   clk, rst_n          clock, async active-low reset
//   s_bit, s_valid      unstuffed covered bits (after PID), LSB-first
//   start, endr         first-bit pulse / end-of-packet pulse
//   pkt_type            packet class, sampled with start
//   m_bit, m_valid      forwarded payload bits (CRC field removed)
//   m_start, m_end      first forwarded bit / end-of-packet (with done)
//   done                verdict strobe, one cycle after endr
//   crc_ok/crc_err/len_err  one-hot verdict qualified by done
//
// state | meaning
// IDLE  | waiting for start
// RECV  | consuming covered bits, forwarding delayed payload
// DONE  | verdict cycle; start here begins a new packet
module usb_crc_check
   import usb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_bit,
   input  logic       s_valid,
   input  logic       start,
   input  logic       endr,
   input  logic [1:0] pkt_type,
   output logic       m_bit,
   output logic       m_valid,
   output logic       m_start,
   output logic       m_end,
   output logic       done,
   output logic       crc_ok,
   output logic       crc_err,
   output logic       len_err
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_e;

   state_e      state_q;
   pkt_type_e   type_q, cur_type;
   logic [15:0] dly_q;
   logic [4:0]  fill_q, w_sel;
   logic [13:0] cnt_q, cnt_inc, cnt_fin;
   logic        first_q;
   logic        m_bit_q, m_valid_q, m_start_q, m_end_q, done_q;
   logic        crc_ok_q, crc_err_q, len_err_q;

   logic        take, en5, en16, fwd_type, tap, len_ok, crc_bad;
   logic [4:0]  crc5, res5;
   logic [15:0] crc16, res16;

   always_comb begin
      cur_type = start ? pkt_type_e'(pkt_type) : type_q;
      take     = s_valid && (start || state_q == S_RECV);
      en5      = take && cur_type == PKT_TOKEN;
      en16     = take && cur_type == PKT_DATA;
   end

   usb_crc_lfsr #(.W(CRC5_W), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (start),
      .en_i  (en5),
      .bit_i (s_bit),
      .crc_o (crc5)
   );

   usb_crc_lfsr #(.W(CRC16_W), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (start),
      .en_i  (en16),
      .bit_i (s_bit),
      .crc_o (crc16)
   );

   // Verdict is registered on the endr cycle, so it must include a bit
   // arriving in that same cycle: look one step ahead of the CRC registers.
   always_comb begin
      fwd_type = (type_q == PKT_DATA) || (type_q == PKT_TOKEN);
      w_sel    = (type_q == PKT_TOKEN) ? 5'd5 : 5'd16;
      tap      = (type_q == PKT_TOKEN) ? dly_q[4] : dly_q[15];
      cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 14'd1;
      cnt_fin  = s_valid ? cnt_inc : cnt_q;
      res5     = s_valid ? crc5_next(crc5, s_bit) : crc5;
      res16    = s_valid ? crc16_next(crc16, s_bit) : crc16;
      len_ok   = 1'b0;
      crc_bad  = 1'b0;
      case (type_q)
         PKT_DATA: begin
            len_ok  = (cnt_fin >= DATA_MIN_LEN) && (cnt_fin[2:0] == 3'd0) &&
                      (cnt_fin <= DATA_MAX_LEN);
            crc_bad = (res16 != CRC16_RESIDUE);
         end
         PKT_TOKEN: begin
            len_ok  = (cnt_fin == TOKEN_LEN);
            crc_bad = (res5 != CRC5_RESIDUE);
         end
         PKT_HSHAKE: len_ok = (cnt_fin == 14'd0);
         default:    len_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         type_q    <= PKT_DATA;
         dly_q     <= '0;
         fill_q    <= '0;
         cnt_q     <= '0;
         first_q   <= 1'b0;
         m_bit_q   <= 1'b0;
         m_valid_q <= 1'b0;
         m_start_q <= 1'b0;
         m_end_q   <= 1'b0;
         done_q    <= 1'b0;
         crc_ok_q  <= 1'b0;
         crc_err_q <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         m_valid_q <= 1'b0;
         m_start_q <= 1'b0;
         m_end_q   <= 1'b0;
         done_q    <= 1'b0;
         crc_ok_q  <= 1'b0;
         crc_err_q <= 1'b0;
         len_err_q <= 1'b0;
         if (start) begin
            // New packet from any state; an open packet is dropped silently.
            state_q <= S_RECV;
            type_q  <= pkt_type_e'(pkt_type);
            first_q <= 1'b0;
            cnt_q   <= s_valid ? 14'd1 : 14'd0;
            dly_q   <= {15'd0, s_bit & s_valid};
            fill_q  <= (s_valid && (pkt_type_e'(pkt_type) == PKT_DATA ||
                                    pkt_type_e'(pkt_type) == PKT_TOKEN)) ? 5'd1 : 5'd0;
         end else begin
            case (state_q)
               S_RECV: begin
                  if (s_valid) begin
                     cnt_q <= cnt_inc;
                     if (fwd_type) begin
                        dly_q <= {dly_q[14:0], s_bit};
                        if (fill_q == w_sel) begin
                           m_valid_q <= 1'b1;
                           m_bit_q   <= tap;
                           m_start_q <= !first_q;
                           first_q   <= 1'b1;
                        end else begin
                           fill_q <= fill_q + 5'd1;
                        end
                     end
                  end
                  if (endr) begin
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     m_end_q   <= 1'b1;
                     len_err_q <= !len_ok;
                     crc_err_q <= len_ok && crc_bad;
                     crc_ok_q  <= len_ok && !crc_bad;
                  end
               end
               S_DONE:  state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign m_bit   = m_bit_q;
   assign m_valid = m_valid_q;
   assign m_start = m_start_q;
   assign m_end   = m_end_q;
   assign done    = done_q;
   assign crc_ok  = crc_ok_q;
   assign crc_err = crc_err_q;
   assign len_err = len_err_q;

endmodule

// File: tb/tb_usb_crc_check.sv
module tb_usb_crc_check;
   import usb_pkg::*;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       s_bit = 1'b0, s_valid = 1'b0, start = 1'b0, endr = 1'b0;
   logic [1:0] pkt_type = 2'd0;
   logic       m_bit, m_valid, m_start, m_end, done, crc_ok, crc_err, len_err;

   usb_crc_check dut (
      .clk(clk), .rst_n(rst_n), .s_bit(s_bit), .s_valid(s_valid),
      .start(start), .endr(endr), .pkt_type(pkt_type),
      .m_bit(m_bit), .m_valid(m_valid), .m_start(m_start), .m_end(m_end),
      .done(done), .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic ok; logic cerr; logic lerr;} verdict_t;

   int       checks = 0, errors = 0;
   logic     pkt_bits[$];
   logic     exp_bits[$];
   logic     exp_first[$];
   verdict_t exp_v[$];
   logic [7:0] payload[$];
   logic     mark_end = 1'b0;
   logic     done_due = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // CRC over the first nb bits of pkt_bits, straight from the definition.
   function automatic logic [15:0] crc_calc(input int w, input logic [15:0] poly, input int nb);
      logic [15:0] r, mask;
      logic        fb;
      mask = 16'((32'd1 << w) - 32'd1);
      r    = mask;
      for (int i = 0; i < nb; i++) begin
         fb = r[w-1] ^ pkt_bits[i];
         r  = (r << 1) & mask;
         if (fb) r = r ^ poly;
      end
      return r;
   endfunction

   function automatic verdict_t model_verdict(input logic [1:0] t);
      int n;
      logic lok, bad;
      verdict_t v;
      n = pkt_bits.size();
      lok = 1'b0; bad = 1'b0;
      if (t == 2'd0) begin
         lok = (n >= 16) && (n % 8 == 0) && (n <= 8 * 1023 + 16);
         bad = crc_calc(16, 16'h8005, n) != 16'h800D;
      end else if (t == 2'd1) begin
         lok = (n == 16);
         bad = crc_calc(5, 16'h0005, n) != 16'h000C;
      end else if (t == 2'd2) begin
         lok = (n == 0);
      end
      v.lerr = !lok;
      v.cerr = lok && bad;
      v.ok   = lok && !bad;
      return v;
   endfunction

   task automatic build_data();
      logic [15:0] rem;
      pkt_bits.delete();
      foreach (payload[k])
         for (int b = 0; b < 8; b++) pkt_bits.push_back(payload[k][b]);
      rem = ~crc_calc(16, 16'h8005, pkt_bits.size());
      for (int b = 15; b >= 0; b--) pkt_bits.push_back(rem[b]);
   endtask

   task automatic build_token(input logic [6:0] addr, input logic [3:0] endp);
      logic [15:0] rem;
      pkt_bits.delete();
      for (int b = 0; b < 7; b++) pkt_bits.push_back(addr[b]);
      for (int b = 0; b < 4; b++) pkt_bits.push_back(endp[b]);
      rem = ~crc_calc(5, 16'h0005, 11);
      for (int b = 4; b >= 0; b--) pkt_bits.push_back(rem[b]);
   endtask

   // Payload is everything except the trailing W bits; handshakes forward nothing.
   task automatic expect_pkt(input logic [1:0] t, input bit with_verdict);
      int w, nf;
      w  = (t == 2'd1) ? 5 : 16;
      nf = (t == 2'd2) ? 0 : pkt_bits.size() - w;
      for (int i = 0; i < nf; i++) begin
         exp_bits.push_back(pkt_bits[i]);
         exp_first.push_back(i == 0);
      end
      if (with_verdict) exp_v.push_back(model_verdict(t));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         s_valid = 1'b0; start = 1'b0; endr = 1'b0; mark_end = 1'b0;
      end
   endtask

   task automatic drive(input logic [1:0] t, input int gap_every, input int gap_len,
                        input bit with_last, input bit do_end);
      int n;
      n = pkt_bits.size();
      for (int i = 0; i < n; i++) begin
         if (gap_every > 0 && i > 0 && i % gap_every == 0) idle(gap_len);
         tick();
         s_bit    = pkt_bits[i];
         s_valid  = 1'b1;
         start    = (i == 0);
         pkt_type = t;
         endr     = do_end && with_last && (i == n - 1);
         mark_end = endr;
      end
      if (do_end && !with_last) begin
         tick();
         s_valid = 1'b0; start = 1'b0; endr = 1'b1; mark_end = 1'b1;
      end
      idle(1);
   endtask

   task automatic settle(input string name);
      idle(4);
      chk({name, "_leftover_bits"}, exp_bits.size(), 0);
      chk({name, "_leftover_verdict"}, exp_v.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         done_due = 1'b0;
      end else begin
         chk("done_timing", done, done_due);
         chk("m_end_with_done", m_end, done);
         chk("verdict_onehot", $countones({crc_ok, crc_err, len_err}), done ? 1 : 0);
         if (m_valid) begin
            if (exp_bits.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_m_valid actual=1 required=0");
            end else begin
               chk("m_bit", m_bit, exp_bits.pop_front());
               chk("m_start", m_start, exp_first.pop_front());
            end
         end else begin
            chk("m_start_qualified", m_start, 0);
         end
         if (done) begin
            if (exp_v.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               chk("verdict", {crc_ok, crc_err, len_err}, exp_v.pop_front());
            end
            chk("bits_before_done", exp_bits.size(), 0);
         end
         done_due = mark_end;
      end
   end

   initial begin
      logic [15:0] field;
      verdict_t    v;

      idle(3);
      chk("reset_outputs", {m_bit, m_valid, m_start, m_end, done, crc_ok, crc_err, len_err}, 0);
      tick();
      rst_n = 1'b1;
      idle(2);

      // Zero-length DATA: CRC field of an empty payload is all zeros.
      payload.delete();
      build_data();
      field = '0;
      foreach (pkt_bits[i]) field[i] = pkt_bits[i];
      chk("pin_empty_field", field, 16'h0000);
      chk("pin_res16", crc_calc(16, 16'h8005, 16), 16'h800D);
      v = model_verdict(2'd0);
      chk("pin_empty_ok", v, 3'b100);
      expect_pkt(2'd0, 1);
      drive(2'd0, 0, 0, 0, 1);
      settle("zero_data");

      // 4-byte DATA, good, then with payload bit 5 flipped.
      payload = '{8'h00, 8'h01, 8'h02, 8'h03};
      build_data();
      chk("pin_data_len", pkt_bits.size(), 48);
      expect_pkt(2'd0, 1);
      drive(2'd0, 0, 0, 0, 1);
      settle("data4");

      build_data();
      pkt_bits[5] = ~pkt_bits[5];
      v = model_verdict(2'd0);
      chk("pin_flip_crcerr", v, 3'b010);
      expect_pkt(2'd0, 1);
      drive(2'd0, 0, 0, 0, 1);
      settle("data4_flip");

      // Token addr 15h endp Eh; CRC5 field is 17h sent MSB first.
      build_token(7'h15, 4'hE);
      field = '0;
      for (int b = 0; b < 5; b++) field[4-b] = pkt_bits[11+b];
      chk("pin_crc5", field, 16'h0017);
      chk("pin_res5", crc_calc(5, 16'h0005, 16), 16'h000C);
      expect_pkt(2'd1, 1);
      drive(2'd1, 0, 0, 0, 1);
      settle("token");

      // Short token (15 bits).
      build_token(7'h15, 4'hE);
      void'(pkt_bits.pop_back());
      v = model_verdict(2'd1);
      chk("pin_short_token", v, 3'b001);
      expect_pkt(2'd1, 1);
      drive(2'd1, 0, 0, 0, 1);
      settle("token15");

      // Gapped DATA: 8 idle cycles every 3 bits.
      build_data();
      expect_pkt(2'd0, 1);
      drive(2'd0, 3, 8, 0, 1);
      settle("data_gaps");

      // endr coincident with the last bit.
      build_data();
      expect_pkt(2'd0, 1);
      drive(2'd0, 0, 0, 1, 1);
      settle("data_endr_last");

      // Abort after 7 token bits, then a full token.
      build_token(7'h15, 4'hE);
      while (pkt_bits.size() > 7) void'(pkt_bits.pop_back());
      expect_pkt(2'd1, 0);
      drive(2'd1, 0, 0, 0, 0);
      build_token(7'h3A, 4'hA);
      expect_pkt(2'd1, 1);
      drive(2'd1, 0, 0, 0, 1);
      settle("token_abort");

      // Reset mid-data, then a clean packet.
      build_data();
      while (pkt_bits.size() > 20) void'(pkt_bits.pop_back());
      expect_pkt(2'd0, 0);
      drive(2'd0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("reset_mid_outputs", {m_bit, m_valid, m_start, m_end, done, crc_ok, crc_err, len_err}, 0);
      exp_bits.delete(); exp_first.delete(); exp_v.delete();
      idle(2);
      rst_n = 1'b1;
      idle(1);
      payload = '{8'hA5, 8'h5A};
      build_data();
      expect_pkt(2'd0, 1);
      drive(2'd0, 0, 0, 0, 1);
      settle("after_reset");

      // Handshake with one stray bit.
      pkt_bits.delete();
      pkt_bits.push_back(1'b1);
      expect_pkt(2'd2, 1);
      drive(2'd2, 0, 0, 0, 1);
      settle("hshake_bit");

      // DATA of 17 bits: not a byte multiple.
      payload.delete();
      build_data();
      pkt_bits.push_back(1'b0);
      expect_pkt(2'd0, 1);
      drive(2'd0, 0, 0, 0, 1);
      settle("data17");

      // endr while idle is ignored (compare process requires done low).
      tick();
      endr = 1'b1; mark_end = 1'b0;
      idle(1);
      settle("endr_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_crc_check.md
# usb_crc_check

Receive-side CRC checker for the USB serial path, between the bit unstuffer and the packet decoder. It is the counterpart of the transmit CRC inserter. It accepts the unstuffed bits covered by CRC (everything after the PID) and runs CRC5 for tokens or CRC16 for data packets over them. It strips the trailing CRC field and forwards only payload bits downstream, then reports a CRC/length verdict one cycle after end-of-packet.

## Interface
- No parameters; all widths and constants come from `usb_pkg`.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- s_bit  input  1  unstuffed serial bit, LSB-first as on the wire.
- s_valid  input  1  s_bit is valid this cycle; low means a stuff-bit hole or idle.
- start  input  1  one-cycle pulse coincident with the first covered bit (s_valid is also high).
- endr  input  1  one-cycle pulse after the last covered bit (EOP seen).
- pkt_type  input  2  `PKT_DATA`=0, `PKT_TOKEN`=1, `PKT_HSHAKE`=2; sampled with start.
- m_bit  output  1  forwarded payload bit.
- m_valid  output  1  m_bit valid.
- m_start  output  1  marks the first forwarded payload bit.
- m_end  output  1  end-of-packet pulse, same cycle as done.
- done  output  1  one-cycle verdict strobe.
- crc_ok  output  1  qualified by done: residue matched and length is legal.
- crc_err  output  1  qualified by done: residue mismatch.
- len_err  output  1  qualified by done: illegal covered-bit count.

## Operation
- FSM states: IDLE, RECV, DONE.
  - IDLE→RECV on start; load pkt_type and consume the first bit.
  - RECV→DONE on endr.
  - DONE→IDLE unconditionally after 1 cycle.
  - start in DONE is honoured, going directly to RECV.
- CRC register, width W (5 for token, 16 for data), init all ones.
  - Per valid bit: fb = crc[W-1]^s_bit; crc <= {crc[W-2:0],1'b0} ^ (fb ? POLY : 0).
  - POLY5=5'b00101, POLY16=16'h8005.
  - After all covered bits (data + received CRC), the good residue is 5'b01100 or 16'h800D.
- CRC stripping uses a 16-bit delay shift register plus fill counter (0..W).
  - Each valid bit is shifted in.
  - When fill==W, the oldest bit (position W-1) is emitted on m_bit; otherwise fill increments.
  - Bits still held at endr are the CRC field and are discarded.
- Bit counter: 14-bit count of covered bits, saturating at 16383.
- Length rules:
  - Token: exactly 16.
  - Data: count ≥16, count%8==0, count ≤ 8*1023+16.
  - Handshake: count 0.
- Handshake packets get no CRC. If any bit arrives, it is counted and not forwarded. At done: crc_ok=(count==0), len_err otherwise, crc_err=0.
- Verdict: len_err takes precedence. crc_err=!len_err && residue≠good. crc_ok=!len_err && !crc_err. Exactly one of the three is high with done.
- Boundary cases:
  - start while in RECV: the current packet is aborted silently (no done, no m_end); the delay line and fill counter clear; the new packet starts with this bit.
  - endr in IDLE: ignored.
  - endr and s_valid in the same cycle: the bit is consumed first, then the packet ends.
  - s_valid outside a packet (IDLE/DONE without start): ignored.
  - rst_n low mid-packet: everything clears immediately; no done is produced.

## Timing
- Reset values: all outputs 0, FSM IDLE, crc all ones, fill 0, count 0.
- m_bit/m_valid are registered, 1 cycle after the s_valid cycle that pushes the W-th-older bit out. Payload latency is W valid bits plus 1 clock.
- m_start accompanies the first m_valid of the packet.
- done/m_end/verdict are registered, 1 cycle after endr; all are single-cycle pulses.
- The last m_valid of a packet always precedes or coincides with done.
- Gaps in s_valid stall everything; no bit is lost or duplicated.

## Structure
- `usb_pkg` holds:
  - the pkt_type enum;
  - CRC5/CRC16 widths, polynomials, init values and residues;
  - the max data length.
- `usb_crc_lfsr` is a separate sub-module with parameter W and POLY, ports clk/rst_n/clr/en/bit/crc. It is instantiated twice (W=5, W=16), and the FSM selects which one is active.
- The delay line, counters and FSM are in the top level.

## Test plan
- Zero-length DATA: start, 16 zero bits, endr → no m_valid, done with crc_ok=1, residue 16'h800D.
- 4-byte DATA 8'h00,01,02,03 with CRC16 from the golden model → 32 m_valid bits matching the payload LSB-first, crc_ok=1. Flip payload bit 5 → crc_err=1, crc_ok=0.
- Token addr 7'h15, endp 4'hE with model CRC5 → 11 forwarded bits, crc_ok=1. Send only 15 bits → len_err=1, crc_err=0.
- DATA with 8-cycle s_valid gaps inserted every 3 bits → identical m_bit stream and verdict as the gapless run.
- start reasserted mid-token after 7 bits, then a full valid token → exactly one done (crc_ok=1) and 11 forwarded bits after the restart.
- rst_n pulsed low mid-data packet → all outputs 0 at once; a following clean packet passes with crc_ok=1.
